// File: rtl/shift8_pkg.sv
// Shared encodings for the 8-bit shift sequencer: shift ops, FSM states, step width.
// Rotate support is controlled by the SHIFT_SEQ8_ROR_EN macro in shift8_stage.
package shift8_pkg;

    typedef enum logic [1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    localparam int STEP_W = 2;

endpackage

// File: rtl/shift8_stage.sv
// Combinational 8-bit shift stage moving 0-3 positions.
// Op 11 rotates right with SHIFT_SEQ8_ROR_EN defined; otherwise it passes acc through.
module shift8_stage
    import shift8_pkg::*;
(
    input  logic [7:0]        acc,
    input  op_e               op,
    input  logic [STEP_W-1:0] k,
    output logic [7:0]        res
);

`ifdef SHIFT_SEQ8_ROR_EN
    logic [15:0] rot;
    // Shifting a doubled copy right drops the wrapped bits into the low byte.
    always_comb rot = {acc, acc} >> k;
`endif

    always_comb begin
        res = acc;
        case (op)
            OP_LSL: res = acc << k;
            OP_LSR: res = acc >> k;
            OP_ASR: res = unsigned'($signed(acc) >>> k);
`ifdef SHIFT_SEQ8_ROR_EN
            OP_ROR: res = rot[7:0];
`else
            OP_ROR: res = acc;
`endif
            default: res = acc;
        endcase
    end

endmodule

// File: rtl/shift_seq8.sv
// Multi-cycle 8-bit shift sequencer: start/done handshake, up to 3 positions per SHIFT cycle.
// Optional rotate (op 11) is enabled by SHIFT_SEQ8_ROR_EN.
module shift_seq8
    import shift8_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [7:0] d_in,
    input  logic [2:0] shamt,
    output logic       busy,
    output logic       done,
    output logic [7:0] d_out
);

    // Handshake: start is sampled only in IDLE; done is a one-cycle pulse with d_out
    // valid in that cycle; busy covers SHIFT and DONE, so start while busy is dropped.
    state_e            state, state_nx;
    op_e               op_r, op_r_nx;
    logic [7:0]        acc, acc_nx, d_out_nx, stage_res;
    logic [2:0]        rem, rem_nx, rem_after;
    logic [STEP_W-1:0] step;

    always_comb step = (rem > 3'd3) ? 2'd3 : rem[1:0];
    always_comb rem_after = rem - {1'b0, step};

    shift8_stage u_stage (
        .acc (acc),
        .op  (op_r),
        .k   (step),
        .res (stage_res)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            acc   <= 8'h00;
            rem   <= 3'd0;
            op_r  <= OP_LSL;
            d_out <= 8'h00;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            rem   <= rem_nx;
            op_r  <= op_r_nx;
            d_out <= d_out_nx;
        end
    end

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        rem_nx   = rem;
        op_r_nx  = op_r;
        d_out_nx = d_out;
        case (state)
            S_IDLE: begin
                if (start) begin
                    acc_nx   = d_in;
                    rem_nx   = shamt;
                    op_r_nx  = op_e'(op);
                    state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // A zero amount still spends one SHIFT cycle with step 0.
                acc_nx = stage_res;
                rem_nx = rem_after;
                if (rem_after == 3'd0) begin
                    d_out_nx = stage_res;
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_shift_seq8.sv
// Self-checking bench for shift_seq8: directed cases, random requests against a full-shift model.
// Expectations for op 11 follow SHIFT_SEQ8_ROR_EN, matching the RTL build.
module tb_shift_seq8;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] op;
    logic [7:0] d_in;
    logic [2:0] shamt;
    logic       busy;
    logic       done;
    logic [7:0] d_out;

    int checks = 0;
    int errors = 0;
    logic [7:0] last_out;

    shift_seq8 dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .d_in  (d_in),
        .shamt (shamt),
        .busy  (busy),
        .done  (done),
        .d_out (d_out)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Whole-amount shift computed in one go with integer arithmetic.
    function automatic logic [7:0] ref_shift(input logic [1:0] o, input logic [7:0] d, input int s);
        int v;
        int dv;
        dv = int'(d);
        case (o)
            2'b00: v = (dv << s) & 255;
            2'b01: v = dv >> s;
            2'b10: v = (dv >> s) | ((dv >= 128) ? ((255 << (8 - s)) & 255) : 0);
`ifdef SHIFT_SEQ8_ROR_EN
            default: v = ((dv >> s) | (dv << (8 - s))) & 255;
`else
            default: v = dv;
`endif
        endcase
        return v[7:0];
    endfunction

    function automatic int ref_done_cycle(input int s);
        int n;
        n = (s == 0) ? 1 : (s + 2) / 3;
        return n + 1;
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge; presents a request for one edge and follows it to the
    // first IDLE cycle afterwards (cycle n+2), which is again a negedge.
    task automatic do_req(input logic [1:0] o, input logic [7:0] d, input logic [2:0] s,
                          output int done_cyc, output logic [7:0] res,
                          output int busy_bad, output int held_bad, output int idle_bad);
        int cyc;
        done_cyc = -1;
        res      = 8'hxx;
        busy_bad = 0;
        held_bad = 0;
        idle_bad = 0;
        start = 1'b1;
        op    = o;
        d_in  = d;
        shamt = s;
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom_range(0, 3));
        d_in  = 8'($urandom_range(0, 255));
        shamt = 3'($urandom_range(0, 7));
        for (cyc = 1; cyc <= 12; cyc++) begin
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) begin
                done_cyc = cyc;
                res      = d_out;
                break;
            end
            if (d_out !== last_out) held_bad++;
            @(negedge clk);
        end
        @(negedge clk);
        if (busy !== 1'b0 || done !== 1'b0) idle_bad++;
        if (done_cyc > 0) last_out = res;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        d_in  = 8'h00;
        shamt = 3'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || d_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_values: busy=%b done=%b d_out=%h, want 0 0 00", busy, done, d_out);
        end
        reset = 1'b0;
        last_out = 8'h00;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || d_out !== 8'h00) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b d_out=%h, want 0 0 00", busy, done, d_out);
        end
    endtask

    task automatic test_directed();
        logic [1:0] t_op [6] = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b11, 2'b01};
        logic [7:0] t_d  [6] = '{8'hCC, 8'h88, 8'h1F, 8'h50, 8'h81, 8'hFF};
        logic [2:0] t_s  [6] = '{3'd3, 3'd7, 3'd0, 3'd2, 3'd5, 3'd4};
`ifdef SHIFT_SEQ8_ROR_EN
        logic [7:0] t_exp[6] = '{8'hF9, 8'hFF, 8'h1F, 8'h14, 8'h0C, 8'h0F};
`else
        logic [7:0] t_exp[6] = '{8'hF9, 8'hFF, 8'h1F, 8'h14, 8'h81, 8'h0F};
`endif
        int t_cyc[6] = '{2, 4, 2, 2, 3, 3};
        int dc, bb, hb, ib;
        logic [7:0] r;
        for (int i = 0; i < 6; i++) begin
            do_req(t_op[i], t_d[i], t_s[i], dc, r, bb, hb, ib);
            checks++;
            if (r !== t_exp[i]) begin
                errors++;
                $display("FAIL directed_%0d_data: d_out=%h, want %h", i, r, t_exp[i]);
            end
            checks++;
            if (dc != t_cyc[i]) begin
                errors++;
                $display("FAIL directed_%0d_done_cycle: got %0d, want %0d", i, dc, t_cyc[i]);
            end
            checks++;
            if (bb != 0 || hb != 0 || ib != 0) begin
                errors++;
                $display("FAIL directed_%0d_handshake: busy_low=%0d d_out_moved=%0d not_idle=%0d, want 0 0 0",
                         i, bb, hb, ib);
            end
        end
    endtask

    task automatic test_random();
        int dc, bb, hb, ib;
        logic [7:0] r, d, e;
        logic [1:0] o;
        logic [2:0] s;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            d = 8'($urandom_range(0, 255));
            s = 3'($urandom_range(0, 7));
            e = ref_shift(o, d, int'(s));
            do_req(o, d, s, dc, r, bb, hb, ib);
            checks++;
            if (r !== e || dc != ref_done_cycle(int'(s)) || bb != 0 || hb != 0 || ib != 0) begin
                errors++;
                $display("FAIL random_%0d op=%0d d=%h s=%0d: d_out=%h done_cyc=%0d flags=%0d/%0d/%0d, want %h %0d 0/0/0",
                         i, o, d, s, r, dc, bb, hb, ib, e, ref_done_cycle(int'(s)));
            end
        end
    endtask

    task automatic test_back_to_back();
        int dc, bb, hb, ib, c0, spent, want;
        logic [7:0] r;
        logic [2:0] s;
        logic [7:0] d;
        want = 0;
        c0 = 0;
        spent = 0;
        for (int i = 0; i < 8; i++) begin
            s = 3'($urandom_range(0, 7));
            d = 8'($urandom_range(0, 255));
            want += ref_done_cycle(int'(s)) + 1;
            c0 = $time;
            do_req(2'b01, d, s, dc, r, bb, hb, ib);
            spent += ($time - c0) / 10;
            checks++;
            if (r !== ref_shift(2'b01, d, int'(s))) begin
                errors++;
                $display("FAIL b2b_%0d_data: d_out=%h, want %h", i, r, ref_shift(2'b01, d, int'(s)));
            end
        end
        checks++;
        if (spent != want) begin
            errors++;
            $display("FAIL b2b_throughput: %0d cycles, want %0d", spent, want);
        end
    endtask

    task automatic test_ignore_start();
        int dc;
        dc = -1;
        start = 1'b1;
        op    = 2'b00;
        d_in  = 8'hFF;
        shamt = 3'd6;
        @(negedge clk);
        start = 1'b1;
        op    = 2'b10;
        d_in  = 8'h12;
        shamt = 3'd1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 2; cyc <= 10; cyc++) begin
            if (done === 1'b1) begin
                dc = cyc;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (dc != 3 || d_out !== 8'hC0) begin
            errors++;
            $display("FAIL ignore_start: done_cyc=%0d d_out=%h, want 3 c0", dc, d_out);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || d_out !== 8'hC0) begin
                errors++;
                $display("FAIL ignore_start_no_restart: busy=%b d_out=%h, want 0 c0", busy, d_out);
            end
        end
        last_out = 8'hC0;
    endtask

    task automatic test_reset_mid();
        int dc, bb, hb, ib, done_seen;
        logic [7:0] r;
        done_seen = 0;
        start = 1'b1;
        op    = 2'b10;
        d_in  = 8'h88;
        shamt = 3'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || d_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_async: busy=%b done=%b d_out=%h, want 0 0 00", busy, done, d_out);
        end
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) done_seen++;
        end
        reset = 1'b0;
        last_out = 8'h00;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: %0d cycles with activity, want 0", done_seen);
        end
        do_req(2'b00, 8'h1F, 3'd3, dc, r, bb, hb, ib);
        checks++;
        if (r !== 8'hF8 || dc != 2 || bb != 0 || hb != 0 || ib != 0) begin
            errors++;
            $display("FAIL reset_mid_recover: d_out=%h done_cyc=%0d, want f8 2", r, dc);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        d_in  = 8'h00;
        shamt = 3'd0;
        last_out = 8'h00;
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
